// File: rtl/line_mem_bridge_if.sv
// line_mem_bridge_if
//   Word-wide memory port between the line bridge and memory.
//   mem_req    bridge -> mem  beat request
//   mem_we     bridge -> mem  beat is a write
//   mem_addr   bridge -> mem  word address of the beat
//   mem_wdata  bridge -> mem  write data of the beat
//   mem_rdata  mem -> bridge  read data, valid with mem_ready on reads
//   mem_ready  mem -> bridge  beat completes this cycle when high with mem_req
interface line_mem_bridge_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/line_mem_bridge.sv
// line_mem_bridge
//   Serialises cache line refill/writeback requests into 32-bit beats on a
//   word-wide memory port and assembles refill beats back into a line.
//   clk                    clock, rising edge
//   rst                    asynchronous reset, active-low
//   enable_cache_to_ram    cache request level, held until response
//   write_cache_to_ram     1 = writeback, 0 = refill
//   address_cache_to_ram   line address (byte offset bits ignored)
//   data_cache_to_ram_i    writeback line, word i at bits [32i+31:32i]
//   response_ram_to_cache  one-cycle completion pulse
//   data_ram_to_cache_o    last assembled refill line
//   busy                   high whenever not idle
//   mem                    memory port (master side)
//
// state | meaning
// IDLE  | waiting for a cache request
// BEAT  | issuing beats; count selects the word
// DONE  | response pulse, refill line valid
// GAP   | one cycle with enable ignored before returning to IDLE
module line_mem_bridge #(
  parameter int WORDS_PER_LINE = 8,
  parameter int OFF_W          = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable_cache_to_ram,
  input  logic                          write_cache_to_ram,
  input  logic [31:0]                   address_cache_to_ram,
  input  logic [32*WORDS_PER_LINE-1:0]  data_cache_to_ram_i,
  output logic                          response_ram_to_cache,
  output logic [32*WORDS_PER_LINE-1:0]  data_ram_to_cache_o,
  output logic                          busy,
  line_mem_bridge_if.master             mem
);

  localparam int CNT_W = OFF_W - 2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, BEAT, DONE, GAP} state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [31-OFF_W:0]               addr_q, addr_d;
  logic                            we_q, we_d;
  // buf holds the latched writeback line, or the refill line being assembled
  logic [WORDS_PER_LINE-1:0][31:0] buf_q, buf_d;
  logic [WORDS_PER_LINE-1:0][31:0] line_q, line_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^address_cache_to_ram[OFF_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      buf_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      buf_q   <= buf_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    buf_d   = buf_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        if (enable_cache_to_ram) begin
          addr_d  = address_cache_to_ram[31:OFF_W];
          we_d    = write_cache_to_ram;
          buf_d   = data_cache_to_ram_i;
          cnt_d   = '0;
          state_d = BEAT;
        end
      end
      BEAT: begin
        if (mem.mem_ready) begin
          if (!we_q) buf_d[cnt_q] = mem.mem_rdata;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = DONE;
            cnt_d   = '0;
            // publish the refill line only once complete, so the output
            // keeps the previous line for the whole transfer
            if (!we_q) line_d = buf_d;
          end
        end
      end
      DONE:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem.mem_req   = (state_q == BEAT);
  assign mem.mem_we    = (state_q == BEAT) && we_q;
  assign mem.mem_addr  = (state_q == BEAT) ? {addr_q, cnt_q, 2'b00} : '0;
  assign mem.mem_wdata = ((state_q == BEAT) && we_q) ? buf_q[cnt_q] : '0;

  assign response_ram_to_cache = (state_q == DONE);
  assign busy                  = (state_q != IDLE);
  assign data_ram_to_cache_o   = line_q;

endmodule

// File: tb/tb_line_mem_bridge.sv
// tb_line_mem_bridge
//   Scoreboard bench for line_mem_bridge: expected beats and responses are
//   queued when a request is driven and popped as the DUT produces them.
//   A small memory model answers beats with base + word index.
module tb_line_mem_bridge;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic         rd;
    logic [255:0] line;
  } resp_t;

  logic         clk;
  logic         rst;
  logic         enable;
  logic         write;
  logic [31:0]  addr;
  logic [255:0] din;
  logic         response;
  logic [255:0] data_o;
  logic         busy;

  line_mem_bridge_if mem_if();

  line_mem_bridge dut (
    .clk                   (clk),
    .rst                   (rst),
    .enable_cache_to_ram   (enable),
    .write_cache_to_ram    (write),
    .address_cache_to_ram  (addr),
    .data_cache_to_ram_i   (din),
    .response_ram_to_cache (response),
    .data_ram_to_cache_o   (data_o),
    .busy                  (busy),
    .mem                   (mem_if)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int resp_cnt = 0;
  int n_stall = 0;

  beat_t exp_beats[$];
  resp_t exp_resp[$];

  logic [255:0] last_line = '0;
  logic [31:0]  rd_base = '0;
  logic         stall_mode = 1'b0;
  logic         ready_tgl = 1'b0;

  logic         stalled = 1'b0;
  logic [31:0]  held_addr;
  logic [31:0]  held_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rd_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction

  // memory model: ready pattern and read data settle shortly after each edge
  always @(posedge clk) begin
    #1;
    ready_tgl = ~ready_tgl;
    mem_if.mem_ready = stall_mode ? ready_tgl : 1'b1;
    mem_if.mem_rdata = rd_base + 32'(mem_if.mem_addr[4:2]);
  end

  // monitor: beats and responses against the scoreboard
  always @(negedge clk) begin
    beat_t b;
    resp_t r;
    if (rst) begin
      if (stalled && mem_if.mem_req) begin
        chk("stall_addr", 256'(mem_if.mem_addr), 256'(held_addr));
        chk("stall_wdata", 256'(mem_if.mem_wdata), 256'(held_wdata));
      end
      stalled = 1'b0;
      if (mem_if.mem_req) begin
        if (mem_if.mem_ready) begin
          if (exp_beats.size() == 0) chk("beat_extra", 256'(1), '0);
          else begin
            b = exp_beats.pop_front();
            chk("beat_addr", 256'(mem_if.mem_addr), 256'(b.addr));
            chk("beat_we", 256'(mem_if.mem_we), 256'(b.we));
            if (b.we) chk("beat_wdata", 256'(mem_if.mem_wdata), 256'(b.wdata));
          end
        end else begin
          stalled    = 1'b1;
          held_addr  = mem_if.mem_addr;
          held_wdata = mem_if.mem_wdata;
          n_stall++;
        end
      end
      if (response) begin
        resp_cnt++;
        if (exp_resp.size() == 0) chk("resp_extra", 256'(1), '0);
        else begin
          r = exp_resp.pop_front();
          if (r.rd) begin
            chk("rd_line", data_o, r.line);
            last_line = r.line;
          end else begin
            chk("wr_keeps_line", data_o, last_line);
          end
        end
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic issue(input logic we, input logic [31:0] a,
                       input logic [255:0] d, input logic [255:0] exp_line);
    beat_t b;
    resp_t r;
    for (int i = 0; i < 8; i++) begin
      b.we    = we;
      b.addr  = {a[31:5], i[2:0], 2'b00};
      b.wdata = d[32*i +: 32];
      exp_beats.push_back(b);
    end
    r.rd   = !we;
    r.line = exp_line;
    exp_resp.push_back(r);
    enable = 1'b1;
    write  = we;
    addr   = a;
    din    = d;
  endtask

  task automatic wait_resp(output int rc);
    int  n = 0;
    bit  hit = 0;
    rc = -1;
    while (!hit && n < 200) begin
      @(negedge clk);
      if (response) begin
        hit = 1;
        rc  = cyc;
      end
      n++;
    end
    if (!hit) chk("resp_timeout", '0, 256'(1));
  endtask

  task automatic wait_beat(input int idx);
    int n = 0;
    bit hit = 0;
    while (!hit && n < 100) begin
      @(negedge clk);
      if (mem_if.mem_req && mem_if.mem_addr[4:2] == idx[2:0]) hit = 1;
      n++;
    end
    if (!hit) chk("beat_timeout", '0, 256'(1));
  endtask

  task automatic drain(input string tag);
    repeat (3) @(negedge clk);
    chk({tag, "_beats_left"}, 256'(exp_beats.size()), '0);
    chk({tag, "_resp_left"}, 256'(exp_resp.size()), '0);
    chk({tag, "_idle"}, 256'(busy), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] wline;
    int c0, rc, r0;
    rst    = 1'b0;
    enable = 1'b0;
    write  = 1'b0;
    addr   = '0;
    din    = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", 256'(mem_if.mem_req), '0);
    chk("rst_busy", 256'(busy), '0);
    chk("rst_resp", 256'(response), '0);
    chk("rst_line", data_o, '0);
    chk("rst_addr", 256'(mem_if.mem_addr), '0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: writeback, ready always high, latency and latched data
    for (int i = 0; i < 8; i++) wline[32*i +: 32] = 32'h1111_1111 * i;
    c0 = cyc;
    issue(1'b1, 32'h0000_1234, wline, '0);
    @(negedge clk);
    enable = 1'b0;
    din    = ~wline;
    wait_resp(rc);
    chk("t1_latency", 256'(rc - c0), 256'(9));
    drain("t1");

    // 2: refill with ready low every other cycle
    stall_mode = 1'b1;
    rd_base    = 32'hA000_0000;
    issue(1'b0, 32'h8000_0040, {8{32'hDEAD_BEEF}}, rd_line(32'hA000_0000));
    @(negedge clk);
    enable = 1'b0;
    wait_resp(rc);
    drain("t2");
    chk("t2_stalls_seen", 256'(n_stall > 0), 256'(1));
    stall_mode = 1'b0;

    // 3: reset during beat 4, then a fresh refill
    rd_base = 32'h5000_0000;
    issue(1'b0, 32'h0000_3000, '0, rd_line(32'h5000_0000));
    @(negedge clk);
    enable = 1'b0;
    wait_beat(3);
    #2 rst = 1'b0;
    #1;
    chk("t3_req_drop", 256'(mem_if.mem_req), '0);
    chk("t3_busy_drop", 256'(busy), '0);
    chk("t3_line_clear", data_o, '0);
    exp_beats.delete();
    exp_resp.delete();
    last_line = '0;
    r0 = resp_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t3_no_resp", 256'(resp_cnt), 256'(r0));
    rd_base = 32'h6000_0000;
    issue(1'b0, 32'h0000_3000, '0, rd_line(32'h6000_0000));
    @(negedge clk);
    enable = 1'b0;
    wait_resp(rc);
    drain("t3");

    // 4: writeback then refill with enable held high throughout
    for (int i = 0; i < 8; i++) wline[32*i +: 32] = 32'h0C0C_0000 + 32'h101 * i;
    issue(1'b1, 32'h0000_4440, wline, '0);
    wait_resp(rc);
    rd_base = 32'h7000_0000;
    issue(1'b0, 32'h0000_5500, '0, rd_line(32'h7000_0000));
    @(negedge clk);
    chk("t4_gap_busy", 256'(busy), 256'(1));
    @(negedge clk);
    chk("t4_idle_busy", 256'(busy), '0);
    @(negedge clk);
    chk("t4_accept_busy", 256'(busy), 256'(1));
    chk("t4_first_addr", 256'(mem_if.mem_addr), 256'(32'h0000_5500));
    enable = 1'b0;
    wait_resp(rc);
    drain("t4");

    // 5: enable dropped at beat 2 of a refill
    rd_base = 32'h9000_0000;
    r0 = resp_cnt;
    issue(1'b0, 32'h0000_6620, {8{32'h5A5A_5A5A}}, rd_line(32'h9000_0000));
    wait_beat(1);
    enable = 1'b0;
    wait_resp(rc);
    drain("t5");
    repeat (5) @(negedge clk);
    chk("t5_one_resp", 256'(resp_cnt), 256'(r0 + 1));

    // 6: writeback after a refill leaves the refill line in place
    for (int i = 0; i < 8; i++) wline[32*i +: 32] = 32'hF000_000F ^ (32'h1 << i);
    issue(1'b1, 32'h0000_7700, wline, '0);
    @(negedge clk);
    enable = 1'b0;
    wait_resp(rc);
    drain("t6");
    chk("t6_line_kept", data_o, rd_line(32'h9000_0000));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
